// File: rtl/ex_stage.sv
// ex_stage -- execute stage, directly downstream of instruction decode.
//
// Purpose:
//   Lane-parallel ALU (8/16/32/64-bit lanes selected by WW). Load/store request
//   forming. An iterative even/odd-lane unsigned multiply that retires one
//   multiplier bit per cycle and stalls upstream while it runs. All results are
//   registered into the EX/MEM pipeline register.
//   Bit 0 of every bus is the MSB; lane 0 is the most significant lane.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ID_function_bit[0:5] {class[0:1], func[2:5]}: 00 ALU, 01 load, 10 store, 11 NOP
//   ID_rD[0:4]           destination register
//   ID_PPPWW[0:4]        participation mask (passed through) + lane width WW
//   ID_rA_data[0:63]     operand A / store data
//   ID_rB_data[0:63]     operand B / immediate / address
//   ID_WB_en, ID_wmem_en register-write and memory-write intent
//   ex_stall             combinational hold request to IF/ID
//   EX_*                 EX/MEM pipeline register outputs
module ex_stage #(
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:5]            ID_function_bit,
    input  logic [0:4]            ID_rD,
    input  logic [0:4]            ID_PPPWW,
    input  logic [0:63]           ID_rA_data,
    input  logic [0:63]           ID_rB_data,
    input  logic                  ID_WB_en,
    input  logic                  ID_wmem_en,
    output logic                  ex_stall,
    output logic [0:4]            EX_rD,
    output logic [0:4]            EX_PPPWW,
    output logic [0:63]           EX_data,
    output logic                  EX_WB_en,
    output logic                  EX_load,
    output logic                  EX_wmem_en,
    output logic [0:MEM_ADDR_W-1] EX_mem_addr,
    output logic [0:63]           EX_mem_wdata
);
    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Internal buses are descending: numeric values are unchanged, only indices flip.
    logic [5:0]  fn;
    logic [3:0]  func;
    logic [4:0]  pppww;
    logic [1:0]  ww;
    logic [63:0] op_a, op_b;
    logic [5:0]  shimm;
    logic        mul_odd;

    assign fn      = ID_function_bit;
    assign func    = fn[3:0];
    assign pppww   = ID_PPPWW;
    assign ww      = pppww[1:0];
    assign op_a    = ID_rA_data;
    assign op_b    = ID_rB_data;
    assign shimm   = {1'b0, op_b[4:0]};
    assign mul_odd = (func == 4'b1000);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
    logic [4:0]  rd_sh_q, rd_sh_d, ppp_sh_q, ppp_sh_d;

    logic [4:0]            rd_q, rd_d, ppp_q, ppp_d;
    logic [63:0]           data_q, data_d, wdata_q, wdata_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic                  wb_q, wb_d, load_q, load_d, wmem_q, wmem_d;
    logic                  stall_c;

    logic [3:0][63:0] alu_res;
    logic [3:0][63:0] ma_sel, mb_sel, acc_step;

    function automatic logic [5:0] lane_last(input logic [1:0] w);
        case (w)
            2'b00:   return 6'd7;
            2'b01:   return 6'd15;
            2'b10:   return 6'd31;
            default: return 6'd63;
        endcase
    endfunction

    // One ALU result per lane width; the WW field picks which one is used.
    for (genvar g = 0; g < 4; g++) begin : g_width
        localparam int W  = 8 << g;
        localparam int SW = 3 + g;
        for (genvar l = 0; l < 64 / W; l++) begin : g_lane
            logic        [W-1:0]  a_l, b_l, r_l;
            logic signed [W-1:0]  a_s;
            logic        [SW-1:0] sh;
            assign a_l = op_a[l*W +: W];
            assign b_l = op_b[l*W +: W];
            assign a_s = a_l;
            // func[0] marks the immediate shift forms: one amount for all lanes.
            assign sh  = func[0] ? shimm[SW-1:0] : b_l[SW-1:0];
            always_comb begin
                r_l = '0;
                case (func)
                    4'b0000:          r_l = a_l & b_l;
                    4'b0001:          r_l = a_l | b_l;
                    4'b0010:          r_l = a_l ^ b_l;
                    4'b0011:          r_l = ~a_l;
                    4'b0100:          r_l = a_l;
                    4'b0101:          r_l = a_l + b_l;
                    4'b0110:          r_l = a_l - b_l;
                    4'b1010, 4'b1011: r_l = a_l << sh;
                    4'b1100, 4'b1101: r_l = a_l >> sh;
                    4'b1110, 4'b1111: r_l = a_s >>> sh;
                    default:          r_l = '0;
                endcase
            end
            assign alu_res[g][l*W +: W] = r_l;
        end
    end

    // Multiply: each 2W slot holds one product. The even lane is the upper
    // half of the slot (lane 0 is the MSB lane), the odd lane the lower half.
    // Operands are latched zero-extended into their slot so the shift-add
    // below never crosses a slot boundary.
    for (genvar g = 0; g < 3; g++) begin : g_mul
        localparam int W  = 8 << g;
        localparam int SW = 3 + g;
        for (genvar s = 0; s < 32 / W; s++) begin : g_slot
            logic [2*W-1:0] mc, mp, acc;
            logic           mbit;
            assign ma_sel[g][s*2*W +: 2*W] =
                {{W{1'b0}}, (mul_odd ? op_a[s*2*W +: W] : op_a[s*2*W+W +: W])};
            assign mb_sel[g][s*2*W +: 2*W] =
                {{W{1'b0}}, (mul_odd ? op_b[s*2*W +: W] : op_b[s*2*W+W +: W])};
            assign mc   = ma_q[s*2*W +: 2*W];
            assign mp   = mb_q[s*2*W +: 2*W];
            assign acc  = acc_q[s*2*W +: 2*W];
            assign mbit = mp[cnt_q[SW-1:0]];
            assign acc_step[g][s*2*W +: 2*W] = acc + (mbit ? (mc << cnt_q[SW-1:0]) : '0);
        end
    end
    assign ma_sel[3]   = '0;
    assign mb_sel[3]   = '0;
    assign acc_step[3] = '0;

    logic is_alu, is_mulop, live, is_load, is_store, start_mul;
    assign is_alu    = (fn[5:4] == 2'b00);
    assign is_mulop  = is_alu && (func == 4'b0111 || func == 4'b1000);
    assign live      = ID_WB_en || ID_wmem_en;
    assign is_load   = (fn == 6'b010000) && live;
    assign is_store  = (fn == 6'b100000) && live;
    // A 64-bit lane has no 128-bit slot: that multiply is a single-cycle zero.
    assign start_mul = is_mulop && ID_WB_en && (ww != 2'b11);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        rd_sh_d  = rd_sh_q;
        ppp_sh_d = ppp_sh_q;
        rd_d     = '0;
        ppp_d    = '0;
        data_d   = '0;
        wdata_d  = '0;
        addr_d   = '0;
        wb_d     = 1'b0;
        load_d   = 1'b0;
        wmem_d   = 1'b0;
        stall_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mul) begin
                    stall_c  = 1'b1;
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    ma_d     = ma_sel[ww];
                    mb_d     = mb_sel[ww];
                    acc_d    = '0;
                    rd_sh_d  = ID_rD;
                    ppp_sh_d = pppww;
                end else if (is_load) begin
                    load_d = 1'b1;
                    wb_d   = 1'b1;
                    addr_d = op_b[MEM_ADDR_W-1:0];
                    rd_d   = ID_rD;
                    ppp_d  = pppww;
                end else if (is_store) begin
                    wmem_d  = 1'b1;
                    addr_d  = op_b[MEM_ADDR_W-1:0];
                    wdata_d = op_a;
                    ppp_d   = pppww;
                end else if (is_alu && ID_WB_en) begin
                    wb_d   = 1'b1;
                    data_d = alu_res[ww];
                    rd_d   = ID_rD;
                    ppp_d  = pppww;
                end
            end
            S_MUL: begin
                acc_d = acc_step[ppp_sh_q[1:0]];
                if (cnt_q == lane_last(ppp_sh_q[1:0])) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    wb_d    = 1'b1;
                    data_d  = acc_step[ppp_sh_q[1:0]];
                    rd_d    = rd_sh_q;
                    ppp_d   = ppp_sh_q;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ex_stall = stall_c && !rst;

    // ---- EX/MEM register and multiply control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            ppp_q   <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wb_q    <= 1'b0;
            load_q  <= 1'b0;
            wmem_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ppp_q   <= ppp_d;
            data_q  <= data_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
            load_q  <= load_d;
            wmem_q  <= wmem_d;
        end
    end

    // ---- multiply shadow operands and accumulator ----
    always_ff @(posedge clk) begin
        ma_q     <= ma_d;
        mb_q     <= mb_d;
        acc_q    <= acc_d;
        rd_sh_q  <= rd_sh_d;
        ppp_sh_q <= ppp_sh_d;
    end

    assign EX_rD        = rd_q;
    assign EX_PPPWW     = ppp_q;
    assign EX_data      = data_q;
    assign EX_WB_en     = wb_q;
    assign EX_load      = load_q;
    assign EX_wmem_en   = wmem_q;
    assign EX_mem_addr  = addr_q;
    assign EX_mem_wdata = wdata_q;
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    localparam int MEM_ADDR_W = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  fn;
    logic [4:0]  rd, pppww;
    logic [63:0] ra, rb;
    logic        wb, wmem;
    logic        stall;
    logic [4:0]  ex_rd, ex_ppp;
    logic [63:0] ex_data, ex_wdata;
    logic        ex_wb, ex_load, ex_wmem;
    logic [MEM_ADDR_W-1:0] ex_addr;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ex_stage #(.MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .ID_function_bit(fn), .ID_rD(rd), .ID_PPPWW(pppww),
        .ID_rA_data(ra), .ID_rB_data(rb), .ID_WB_en(wb), .ID_wmem_en(wmem),
        .ex_stall(stall), .EX_rD(ex_rd), .EX_PPPWW(ex_ppp), .EX_data(ex_data),
        .EX_WB_en(ex_wb), .EX_load(ex_load), .EX_wmem_en(ex_wmem),
        .EX_mem_addr(ex_addr), .EX_mem_wdata(ex_wdata)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [4:0] p, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r, input logic w, input logic m);
        fn = f; pppww = p; ra = a; rb = b; rd = r; wb = w; wmem = m;
    endtask

    task automatic bubble_in();
        drive(6'b110000, 5'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Reference: lane-by-lane arithmetic, lane 0 = most significant W bits.
    function automatic logic [63:0] ref_alu(input logic [3:0] f, input logic [63:0] a,
                                            input logic [63:0] b, input logic [1:0] ww);
        int w, n, lo, sh;
        logic [63:0] m, x, y, z, r;
        w = 8 << ww;
        n = 64 / w;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r = '0;
        if (f == 4'd7 || f == 4'd8) begin
            if (ww == 2'd3) return '0;
            for (int j = 0; j < n / 2; j++) begin
                lo = 64 - (j + 1) * 2 * w;
                x = (a >> (lo + ((f == 4'd7) ? w : 0))) & m;
                y = (b >> (lo + ((f == 4'd7) ? w : 0))) & m;
                r = r | ((x * y) << lo);
            end
            return r;
        end
        for (int k = 0; k < n; k++) begin
            lo = 64 - (k + 1) * w;
            x = (a >> lo) & m;
            y = (b >> lo) & m;
            sh = f[0] ? int'(64'(b[4:0]) % 64'(w)) : int'(y % 64'(w));
            case (f)
                4'd0: z = x & y;
                4'd1: z = x | y;
                4'd2: z = x ^ y;
                4'd3: z = ~x;
                4'd4: z = x;
                4'd5: z = x + y;
                4'd6: z = x - y;
                4'd10, 4'd11: z = x << sh;
                4'd12, 4'd13: z = x >> sh;
                4'd14, 4'd15: begin
                    z = x >> sh;
                    if (x[w-1]) z = z | (m & ~(m >> sh));
                end
                default: z = '0;
            endcase
            r = r | ((z & m) << lo);
        end
        return r;
    endfunction

    task automatic do_alu(input string tag, input logic [3:0] f, input logic [1:0] ww,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        logic [4:0] r, p;
        r = 5'($urandom);
        p = {3'($urandom), ww};
        drive({2'b00, f}, p, a, b, r, 1'b1, 1'b0);
        #1;
        check({tag, "_stall"}, 64'(stall), 64'd0);
        tick();
        check({tag, "_data"}, ex_data, exp);
        check({tag, "_wb"}, 64'(ex_wb), 64'd1);
        check({tag, "_rd"}, 64'(ex_rd), 64'(r));
        check({tag, "_ppp"}, 64'(ex_ppp), 64'(p));
    endtask

    task automatic do_mul(input string tag, input logic odd, input logic [1:0] ww,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        logic [4:0] r, p;
        int n, w;
        r = 5'($urandom);
        p = {3'($urandom), ww};
        w = 8 << ww;
        drive({2'b00, (odd ? 4'b1000 : 4'b0111)}, p, a, b, r, 1'b1, 1'b0);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            tick();
            // Operand fields are ignored once the multiply has begun.
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rd = 5'($urandom);
            #1;
            check({tag, "_bubble"}, 64'({ex_wb, ex_wmem, ex_load}), 64'd0);
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(w));
        tick();
        check({tag, "_data"}, ex_data, exp);
        check({tag, "_wb"}, 64'(ex_wb), 64'd1);
        check({tag, "_rd"}, 64'(ex_rd), 64'(r));
        check({tag, "_ppp"}, 64'(ex_ppp), 64'(p));
        bubble_in();
    endtask

    initial begin
        logic [3:0]  f;
        logic [1:0]  ww;
        logic [63:0] a, b;
        logic        odd;

        rst = 1'b1;
        bubble_in();
        tick();
        tick();
        check("rst_data", ex_data, 64'd0);
        check("rst_ctl", 64'({ex_wb, ex_load, ex_wmem, stall}), 64'd0);
        check("rst_rd_ppp", 64'({ex_rd, ex_ppp}), 64'd0);
        check("rst_mem", 64'(ex_addr) | ex_wdata, 64'd0);
        rst = 1'b0;

        // Directed cases
        do_alu("add_byte", 4'b0101, 2'b00, 64'h01FF_0000_0000_0000,
               64'h0101_0000_0000_0000, 64'h0200_0000_0000_0000);
        do_alu("srai_half", 4'b1111, 2'b01, 64'h8000_0000_0000_0000,
               64'd4, 64'hF800_0000_0000_0000);
        do_mul("muleu_half", 1'b0, 2'b01, 64'hFFFF_0000_0003_0000,
               64'hFFFF_0000_0005_0000, 64'hFFFE_0001_0000_000F);

        drive(6'b100000, 5'd0, 64'hDEAD_BEEF_0000_0001, 64'h1234, 5'd3, 1'b0, 1'b1);
        tick();
        check("store_wmem", 64'(ex_wmem), 64'd1);
        check("store_addr", 64'(ex_addr), 64'h1234);
        check("store_wdata", ex_wdata, 64'hDEAD_BEEF_0000_0001);
        check("store_wb_load", 64'({ex_wb, ex_load}), 64'd0);
        drive(6'b010000, 5'd0, 64'd0, 64'h1234, 5'd7, 1'b1, 1'b0);
        tick();
        check("load_flags", 64'({ex_load, ex_wb, ex_wmem}), 64'b110);
        check("load_addr", 64'(ex_addr), 64'h1234);
        check("load_data", ex_data, 64'd0);
        check("load_rd", 64'(ex_rd), 64'd7);

        drive(6'b110000, 5'd1, 64'hFFFF, 64'hFFFF, 5'd9, 1'b1, 1'b0);
        tick();
        check("nop_bubble", 64'({ex_wb, ex_wmem, ex_load}), 64'd0);
        drive(6'b000101, 5'd0, 64'h1, 64'h1, 5'd9, 1'b0, 1'b0);
        tick();
        check("nowb_bubble", 64'({ex_wb, ex_wmem, ex_load}), 64'd0);
        drive(6'b010011, 5'd0, 64'h1, 64'h1, 5'd9, 1'b1, 1'b0);
        tick();
        check("undef_bubble", 64'({ex_wb, ex_wmem, ex_load}), 64'd0);
        do_alu("muleu_dword", 4'b0111, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_0000_0003, 64'd0);

        // Reset in the middle of a 32-bit-lane MULOU
        drive(6'b001000, 5'b00010, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              5'd5, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) tick();
        check("mul_mid_stall", 64'(stall), 64'd1);
        rst = 1'b1;
        bubble_in();
        tick();
        check("abort_data", ex_data, 64'd0);
        check("abort_ctl", 64'({ex_wb, ex_load, ex_wmem, stall}), 64'd0);
        check("abort_rd_ppp", 64'({ex_rd, ex_ppp}), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        check("abort_no_wb", 64'({ex_wb, stall}), 64'd0);
        do_alu("add_after_abort", 4'b0101, 2'b10, 64'h0000_0001_FFFF_FFFF,
               64'h0000_0001_0000_0001, 64'h0000_0002_0000_0000);

        // Randomised single-cycle ALU ops against the reference model
        for (int i = 0; i < 48; i++) begin
            f  = 4'($urandom);
            ww = 2'($urandom);
            if (f == 4'd7 || f == 4'd8) ww = 2'b11;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            do_alu("rnd_alu", f, ww, a, b, ref_alu(f, a, b, ww));
        end

        // Randomised multi-cycle multiplies
        for (int i = 0; i < 8; i++) begin
            odd = 1'($urandom);
            ww  = 2'($urandom_range(0, 2));
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            do_mul("rnd_mul", odd, ww, a, b, ref_alu(odd ? 4'd8 : 4'd7, a, b, ww));
        end

        bubble_in();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
